// File: rtl/nibble_serial_adder.sv
// Wide-operand adder that walks a registered operand pair one nibble per clock,
// LSB nibble first, through a 4-bit carry-select stage with a held running carry.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            carry;
  logic [IW-1:0]   idx;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [4:0] sum0;
  logic [4:0] sum1;
  logic [4:0] sel;

  // Carry-select step: both carry-in cases in parallel, registered carry picks one
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (idx == IW'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
    sum0 = {1'b0, nib_a} + {1'b0, nib_b};
    sum1 = {1'b0, nib_a} + {1'b0, nib_b} + 5'd1;
    sel  = carry ? sum1 : sum0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            carry    <= c_in;
            idx      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int unsigned n = 0; n < NIB; n++) begin
            if (idx == IW'(n)) sum[4*n +: 4] <= sel[3:0];
          end
          carry <= sel[4];
          idx   <= idx + IW'(1);
          // Top nibble: carry into the MSB is recovered from the MSB sum bit
          if (idx == IW'(NIB - 1)) begin
            c_out     <= sel[4];
            overflow  <= nib_a[3] ^ nib_b[3] ^ sel[3] ^ sel[4];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomized bench for nibble_serial_adder (WIDTH=16) against a
// plain-arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  int total;
  int bad;
  int nres;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (op_a),
    .b         (op_b),
    .c_in      (op_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic, overflow from operand/result signs
  function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic ci);
    logic [16:0] full;
    logic        ovf;
    full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    ovf  = (x[15] == y[15]) && (full[15] != x[15]);
    return {ovf, full};
  endfunction

  // One full transaction: accept, latency check, optional stall, result drain
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                       input int stall);
    logic [17:0] exp;
    int          waitc;
    int          lat;
    exp = ref_add(x, y, ci);
    @(negedge clk);
    op_a = x; op_b = y; op_cin = ci; in_valid = 1'b1; out_ready = 1'b0;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); op_cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(NIB));
    check("sum", 32'(sum), 32'(exp[15:0]));
    check("c_out", 32'(c_out), 32'(exp[16]));
    check("overflow", 32'(overflow), 32'(exp[17]));
    check("busy_ready", 32'(in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'(exp[15:0]));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (out_valid === 1'b0) nres++;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; nres = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    do_op(16'h1234, 16'h4321, 1'b0, 0);
    check("basic_sum", 32'(sum), 32'h5555);
    do_op(16'hFFFF, 16'h0000, 1'b1, 1);
    check("ripple_c_out", 32'(c_out), 32'd1);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0);
    check("ovf_pos", 32'(overflow), 32'd1);
    do_op(16'h8000, 16'h8000, 1'b0, 2);
    check("ovf_neg_sum", 32'(sum), 32'h0000);

    // Backpressure with a competing request held during DONE
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h1111; op_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 16'h0001; op_b = 16'h0005; op_cin = 1'b0;
    repeat (NIB) begin
      @(posedge clk); #1;
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(sum), 32'h2345);
      check("bp_hold_cout", 32'(c_out), 32'd0);
      check("bp_hold_ovf", 32'(overflow), 32'd0);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_new_accepted", 32'(in_ready), 32'd0);
    repeat (NIB) begin
      @(posedge clk); #1;
    end
    check("bp_new_valid", 32'(out_valid), 32'd1);
    check("bp_new_sum", 32'(sum), 32'h0006);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of RUN
    @(negedge clk);
    op_a = 16'hABCD; op_b = 16'h1111; op_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("partial_sum", 32'(sum), 32'h00DE);
    rst_n = 1'b0;
    #1;
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0002, 16'h0003, 1'b0, 0);
    check("post_rst_sum", 32'(sum), 32'h0005);

    // Randomized operands and stalls
    nres = 0;
    for (int i = 0; i < 1000; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end
    check("result_count", 32'(nres), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
